// File: rtl/i2c_cfg_if.sv
// Table-read and byte-transfer handshake between the config sequencer, the
// board config ROM and the I2C byte-transfer controller.
interface i2c_cfg_if #(
   parameter int IDX_W  = 6,
   parameter int DATA_W = 16
) ();
   logic [IDX_W-1:0]  tbl_index;
   logic [DATA_W+8:0] tbl_entry;   // {is_delay, dev_addr, payload}
   logic              i2c_go;
   logic [DATA_W+7:0] i2c_data;    // {dev_addr, payload}
   logic              i2c_end;
   logic              i2c_ack;

   modport master (output tbl_index, i2c_go, i2c_data,
                   input  tbl_entry, i2c_end, i2c_ack);
   modport slave  (input  tbl_index, i2c_go, i2c_data,
                   output tbl_entry, i2c_end, i2c_ack);
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Walks a configuration table and issues each entry to the I2C controller,
// with timed delay entries, bounded NACK retry and done/error status.
module i2c_cfg_sequencer #(
   parameter int NUM_ENTRIES = 32,
   parameter int IDX_W       = 6,
   parameter int DATA_W      = 16,
   parameter int MAX_RETRY   = 3,
   parameter int GAP_CYCLES  = 4,
   parameter int AUTO_START  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             tick,
   i2c_cfg_if.master        bus,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [IDX_W-1:0] err_index
);
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_DELAY, S_ADVANCE, S_DONE, S_ERROR
   } state_t;

   localparam state_t           RESET_STATE = (AUTO_START != 0) ? S_FETCH : S_IDLE;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);
   localparam int               RETRY_W     = $clog2(MAX_RETRY + 1);
   localparam int               GAP_W       = $clog2(GAP_CYCLES + 2);
   localparam int               XFER_W      = 8 + DATA_W;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    err_idx_q, err_idx_d;
   logic [XFER_W-1:0]   entry_q, entry_d;
   logic [XFER_W-1:0]   data_q, data_d;
   logic                go_q, go_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [DATA_W-1:0]   delay_q, delay_d;
   logic [GAP_W-1:0]    gap_q, gap_d;

   always_comb begin
      // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      err_idx_d = err_idx_q;
      entry_d   = entry_q;
      data_d    = data_q;
      go_d      = go_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      retry_d   = retry_q;
      delay_d   = delay_q;
      gap_d     = gap_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               retry_d = '0;
               busy_d  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            entry_d = bus.tbl_entry[XFER_W-1:0];
            if (bus.tbl_entry[XFER_W]) begin
               delay_d = bus.tbl_entry[DATA_W-1:0];
               state_d = S_DELAY;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Launch only in a tick-high cycle so go lines up with the bus phase.
            if (tick) begin
               data_d  = entry_q;
               go_d    = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.i2c_end) begin
               go_d = 1'b0;
               if (bus.i2c_ack) begin
                  state_d = S_ADVANCE;
               end else if (int'(retry_q) + 1 < MAX_RETRY) begin
                  retry_d = retry_q + 1'b1;
                  gap_d   = '0;
                  state_d = S_GAP;
               end else begin
                  err_idx_d = idx_q;
                  err_d     = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = S_ERROR;
               end
            end
         end
         S_GAP: begin
            if (int'(gap_q) + 1 >= GAP_CYCLES) state_d = S_ISSUE;
            else                               gap_d   = gap_q + 1'b1;
         end
         S_DELAY: begin
            // Leaving as the count reaches zero; a zero payload still spends one cycle here.
            if (delay_q != '0)          delay_d = delay_q - 1'b1;
            if (delay_q <= DATA_W'(1)) state_d = S_ADVANCE;
         end
         S_ADVANCE: begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_DONE, S_ERROR: begin
            go_d   = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               done_d    = 1'b0;
               err_d     = 1'b0;
               err_idx_d = '0;
               idx_d     = '0;
               retry_d   = '0;
               busy_d    = 1'b1;
               state_d   = S_FETCH;
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RESET_STATE;
         idx_q     <= '0;
         err_idx_q <= '0;
         entry_q   <= '0;
         data_q    <= '0;
         go_q      <= 1'b0;
         busy_q    <= (AUTO_START != 0);
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         retry_q   <= '0;
         delay_q   <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         err_idx_q <= err_idx_d;
         entry_q   <= entry_d;
         data_q    <= data_d;
         go_q      <= go_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         retry_q   <= retry_d;
         delay_q   <= delay_d;
         gap_q     <= gap_d;
      end
   end

   assign bus.tbl_index = idx_q;
   assign bus.i2c_go    = go_q;
   assign bus.i2c_data  = data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = err_q;
   assign err_index     = err_idx_q;
endmodule
